ram_fifo: RTL and testbench

RAM_FIFO -- requirements
Module: ram_fifo

---
 rtl/ram_fifo.sv | 94 +++++++++
 tb/tb_ram_fifo.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ram_fifo.sv
// Single-clock FIFO over an inferable dual-port block RAM with registered 1-cycle read.
// Status flags are registered from the next-state count so they never depend on push/pop combinationally.
module ram_fifo #(
    parameter int WIDTH      = 64,
    parameter int DEPTH      = 512,
    parameter int LOG2_DEPTH = $clog2(DEPTH - 1),
    parameter int AF_MARGIN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      d,
    input  logic                  pop,
    output logic [WIDTH-1:0]      q,
    output logic                  q_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [LOG2_DEPTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int CW = LOG2_DEPTH + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - AF_MARGIN);

    logic [WIDTH-1:0]      ram [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr;
    logic [LOG2_DEPTH-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;
    logic [CW-1:0]         count_next;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_next = count - CW'(1);
        end
    end

    // Write port: no reset so the array maps onto block RAM and survives rst.
    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            ram[wr_ptr] <= d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (pop_ok) begin
            q <= ram[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            q_valid     <= 1'b0;
            full        <= 1'b0;
            empty       <= 1'b1;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count       <= count_next;
            q_valid     <= pop_ok;
            full        <= (count_next == FULL_LVL);
            empty       <= (count_next == '0);
            almost_full <= (count_next >= AF_LVL);
            if (push && full) begin
                overflow <= 1'b1;
            end
            if (pop && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ram_fifo.sv
// Self-checking bench for ram_fifo (WIDTH=8, DEPTH=4, AF_MARGIN=1) against a queue-based model.
// Directed scenarios first, then random push/pop with occasional reset.
module tb_ram_fifo;

    localparam int W  = 8;
    localparam int DP = 4;
    localparam int AF = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         push;
    logic [W-1:0] d;
    logic         pop;
    logic [W-1:0] q;
    logic         q_valid;
    logic         full;
    logic         empty;
    logic         almost_full;
    logic [2:0]   count;
    logic         overflow;
    logic         underflow;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [W-1:0] mq[$];
    logic [W-1:0] exp_q;
    logic         exp_qv;
    logic         exp_ovf;
    logic         exp_udf;

    ram_fifo #(.WIDTH(W), .DEPTH(DP), .LOG2_DEPTH(2), .AF_MARGIN(AF)) dut (
        .clk(clk), .rst(rst), .push(push), .d(d), .pop(pop),
        .q(q), .q_valid(q_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        check("count", 32'(count), 32'(n));
        check("full", 32'(full), 32'(n == DP));
        check("empty", 32'(empty), 32'(n == 0));
        check("almost_full", 32'(almost_full), 32'(n >= DP - AF));
        check("q_valid", 32'(q_valid), 32'(exp_qv));
        check("q", 32'(q), 32'(exp_q));
        check("overflow", 32'(overflow), 32'(exp_ovf));
        check("underflow", 32'(underflow), 32'(exp_udf));
    endtask

    task automatic step(input logic r, input logic ps, input logic [W-1:0] dv, input logic pp);
        int  n;
        logic acc_push;
        logic acc_pop;
        @(negedge clk);
        rst  = r;
        push = ps;
        d    = dv;
        pop  = pp;
        @(posedge clk);
        #1;
        n = mq.size();
        if (r) begin
            mq.delete();
            exp_q   = '0;
            exp_qv  = 1'b0;
            exp_ovf = 1'b0;
            exp_udf = 1'b0;
        end else begin
            acc_push = ps && (n != DP);
            acc_pop  = pp && (n != 0);
            if (ps && n == DP) exp_ovf = 1'b1;
            if (pp && n == 0)  exp_udf = 1'b1;
            exp_qv = acc_pop;
            if (acc_pop)  exp_q = mq.pop_front();
            if (acc_push) mq.push_back(dv);
        end
        check_all();
    endtask

    logic [W-1:0] vals [4];

    initial begin
        rst = 1'b1; push = 1'b0; d = '0; pop = 1'b0;
        exp_q = '0; exp_qv = 1'b0; exp_ovf = 1'b0; exp_udf = 1'b0;
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);

        // fill, then overflow attempt, then drain
        for (int i = 0; i < 4; i++) begin
            step(0, 1, vals[i], 0);
            if (i == 2) check("af_at_3", 32'(almost_full), 32'd1);
        end
        check("full_at_4", 32'(full), 32'd1);
        step(0, 1, 8'h55, 0);
        check("ovf_set", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1);
            check("drain_q", 32'(q), 32'(vals[i]));
        end
        step(0, 0, 0, 0);
        check("empty_end", 32'(empty), 32'd1);

        // full with simultaneous push+pop: pop wins, push rejected
        for (int i = 0; i < 4; i++) step(0, 1, 8'(8'hC0 + i), 0);
        step(0, 1, 8'hEE, 1);
        check("fullpp_cnt", 32'(count), 32'd3);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

        // underflow: push+pop on empty
        step(0, 1, 8'hAA, 1);
        check("udf_set", 32'(underflow), 32'd1);
        check("udf_qv", 32'(q_valid), 32'd0);
        step(0, 0, 0, 1);
        check("udf_q", 32'(q), 32'hAA);

        // wrap at count=2, flags clear after reset
        step(1, 0, 0, 0);
        step(0, 1, 8'hF0, 0);
        step(0, 1, 8'hF1, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 8'(i), 1);
        check("wrap_cnt", 32'(count), 32'd2);
        step(0, 0, 0, 1);
        check("wrap_q8", 32'(q), 32'd8);
        step(0, 0, 0, 1);
        check("wrap_q9", 32'(q), 32'd9);

        // mid-operation reset after an accepted pop
        for (int i = 0; i < 3; i++) step(0, 1, 8'(8'h60 + i), 0);
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        check("rst_qv", 32'(q_valid), 32'd0);
        // reset with push and pop asserted must ignore both
        step(0, 1, 8'h61, 0);
        step(1, 1, 8'h62, 1);
        check("rst_prio_cnt", 32'(count), 32'd0);
        step(0, 1, 8'h77, 0);
        step(0, 0, 0, 1);
        check("post_rst_q", 32'(q), 32'h77);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), 1'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
